hazard_stall_unit: RTL
======================

Name: hazard_stall_unit

Overview:
- Issue-side counterpart to the forwarding unit: the forwarding unit consumes results already in flight; this block tracks which instructions are in flight and holds back ID when a needed value cannot be forwarded in time.
- Keeps a shadow pipeline of destination tags for the EX, MEM and WB slots.
- Generates load-use and branch-in-ID stalls.
- Drives PC/IF-ID write-enable hold and the ID/EX bubble insert.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- COUNT_W, 16, stall-statistics counter width (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- id_valid  input  1  ID holds a real instruction.
- id_Rs  input  REG_ADDR_W  source register 1 of the ID instruction.
- id_Rt  input  REG_ADDR_W  source register 2 of the ID instruction.
- id_uses_rt  input  1  ID instruction reads Rt (R-type, store, branch).
- id_dest  input  REG_ADDR_W  destination register chosen in ID (Rd or Rt).
- id_regwrite  input  1  ID instruction writes the register file.
- id_memread  input  1  ID instruction is a load.
- id_is_branch  input  1  ID instruction is beq/bne, which compares in ID.
- flush  input  1  taken branch/jump; discard the ID instruction.
- stall  output  1  hold PC and IF/ID (combinational).
- bubble  output  1  zero the ID/EX control fields this cycle (combinational).
- stall_cycles  output  COUNT_W  number of stall cycles so far (optional feature).

Behaviour:
- Shadow slots EX, MEM, WB. Each slot holds {v, dest, rw, mr}.
  - On rst: every field of every slot = 0.
  - Outputs after reset: stall = 0, bubble = 0, stall_cycles = 0.
- Match function m(slot, r): slot.v && slot.rw && slot.dest != 0 && slot.dest == r.
  - Sources checked: id_Rs always; id_Rt only when id_uses_rt = 1.
- stall is asserted only when id_valid = 1 and flush = 0, and one of these holds:
  - Load-use: EX.mr && m(EX, src).
  - Branch vs ALU producer: id_is_branch && m(EX, src).
  - Branch vs load in MEM: id_is_branch && MEM.mr && m(MEM, src).
- bubble = stall | flush.
- Shift on each clock edge when not in reset:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= bubble ? all-zero : {id_valid, id_dest, id_regwrite, id_memread}.
- Resulting stall counts:
  - Load followed by a dependent ALU instruction: exactly 1 stall cycle.
  - ALU instruction followed by a dependent branch: exactly 1.
  - Load followed by a dependent branch: exactly 2.
- Writes to r0 never stall.
- The WB slot never causes a stall; the register file writes in the first half-cycle. The WB slot exists only for visibility and debug.
- Simultaneous flush and hazard: flush wins. stall = 0, bubble = 1, and the ID instruction is dropped.
- id_valid = 0: no stall; a bubble enters EX.
- rst asserted mid-stall: all slots clear on that edge, and stall falls to 0 on the following cycle, because inputs are re-evaluated against empty slots.
- Latency: stall and bubble respond in the same cycle as their inputs. Shadow state updates one cycle later.

Optional Feature:
- Macro HAZARD_STALL_COUNT_EN.
- Defined:
  - stall_cycles increments by 1 on every clock edge where stall = 1.
  - Saturates at 2^COUNT_W - 1; no wrap-around.
  - Cleared by rst.
- Not defined:
  - stall_cycles is tied to 0.
  - No counter flops are synthesized.

Test Plan:
1. Load-use: lw $8 (dest=8, mr=1) in ID, then add with Rs=8 -> stall=1, bubble=1 for exactly 1 cycle; next cycle stall=0; EX slot holds v=0 during the bubble.
2. Branch after ALU: add dest=9, then beq Rs=9 -> 1 stall cycle. Branch after load: lw dest=9, then beq Rt=9 with uses_rt=1 -> 2 consecutive stall cycles.
3. r0 and unused-Rt cases:
   - lw dest=0, then add Rs=0 -> no stall.
   - lw dest=5, then addi Rt=5 with uses_rt=0 -> no stall.
4. Flush priority: load-use hazard present with flush=1 in the same cycle -> stall=0, bubble=1; following slots show an empty EX entry.
5. Reset mid-operation: assert rst in the middle of the 2-cycle load/branch stall -> all slots clear and stall=0 on the next cycle; stall_cycles=0 when HAZARD_STALL_COUNT_EN is defined.
6. Counter saturation, with HAZARD_STALL_COUNT_EN defined and COUNT_W=4: force 20 stall cycles -> stall_cycles reaches 15 and holds there. With the macro undefined, stall_cycles reads 0 throughout.

Source files
------------

// File: rtl/hazard_stall_unit_if.sv
// ID-stage <-> hazard-stall-unit bundle: decoded source/dest info in, stall/bubble out,
// plus read-only views of the shadow slots for debug.
interface hazard_stall_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int COUNT_W    = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_Rs;
    logic [REG_ADDR_W-1:0] id_Rt;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] id_dest;
    logic                  id_regwrite;
    logic                  id_memread;
    logic                  id_is_branch;
    logic                  flush;

    logic                  stall;
    logic                  bubble;
    logic [COUNT_W-1:0]    stall_cycles;

    // Slot images packed as {v, dest, rw, mr}
    logic [REG_ADDR_W+2:0] dbg_ex;
    logic [REG_ADDR_W+2:0] dbg_mem;
    logic [REG_ADDR_W+2:0] dbg_wb;

    modport master (
        output id_valid, id_Rs, id_Rt, id_uses_rt, id_dest,
               id_regwrite, id_memread, id_is_branch, flush,
        input  stall, bubble, stall_cycles, dbg_ex, dbg_mem, dbg_wb
    );

    modport slave (
        input  id_valid, id_Rs, id_Rt, id_uses_rt, id_dest,
               id_regwrite, id_memread, id_is_branch, flush,
        output stall, bubble, stall_cycles, dbg_ex, dbg_mem, dbg_wb
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Shadow pipeline of destination tags (EX/MEM/WB) driving load-use and branch-in-ID stalls.
// Optional stall-cycle statistics counter enabled by defining HAZARD_STALL_COUNT_EN.
module hazard_stall_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int COUNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_stall_unit_if.slave  bus
);

    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] dest;
        logic                  rw;
        logic                  mr;
    } slot_t;

    slot_t ex_q, ex_d;
    slot_t mem_q;
    slot_t wb_q;

    logic ex_hit, mem_hit;
    logic load_use, branch_ex, branch_mem;
    logic stall_w, bubble_w;

    // r0 is hard-wired zero, so a producer targeting it never creates a dependency
    function automatic logic slot_hit(input slot_t s, input logic [REG_ADDR_W-1:0] r);
        return s.v && s.rw && (s.dest != '0) && (s.dest == r);
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ex_hit     = 1'b0;
        mem_hit    = 1'b0;
        load_use   = 1'b0;
        branch_ex  = 1'b0;
        branch_mem = 1'b0;
        stall_w    = 1'b0;
        bubble_w   = 1'b0;
        ex_d       = '0;

        ex_hit  = slot_hit(ex_q, bus.id_Rs) ||
                  (bus.id_uses_rt && slot_hit(ex_q, bus.id_Rt));
        mem_hit = slot_hit(mem_q, bus.id_Rs) ||
                  (bus.id_uses_rt && slot_hit(mem_q, bus.id_Rt));

        load_use   = ex_q.mr && ex_hit;
        branch_ex  = bus.id_is_branch && ex_hit;
        branch_mem = bus.id_is_branch && mem_q.mr && mem_hit;

        // Flush discards the ID instruction, so it overrides any hazard it carries
        stall_w  = bus.id_valid && !bus.flush && (load_use || branch_ex || branch_mem);
        bubble_w = stall_w || bus.flush;

        if (!bubble_w) begin
            ex_d = '{v: bus.id_valid, dest: bus.id_dest,
                     rw: bus.id_regwrite, mr: bus.id_memread};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so the shift reads pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    assign bus.stall   = stall_w;
    assign bus.bubble  = bubble_w;
    assign bus.dbg_ex  = ex_q;
    assign bus.dbg_mem = mem_q;
    assign bus.dbg_wb  = wb_q;

`ifdef HAZARD_STALL_COUNT_EN
    logic [COUNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (stall_w && (cnt_q != '1)) begin
            cnt_d = cnt_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.stall_cycles = cnt_q;
`else
    assign bus.stall_cycles = '0;
`endif

endmodule
